// File: rtl/tmds_pkg.sv
// tmds_pkg: control symbols, tally type and popcount helper shared by the TMDS encoder.
package tmds_pkg;
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;
  typedef logic signed [4:0] tmds_tally_t;
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/tmds_encoder_tm_choice.sv
// tm_choice: stage 1 transition-minimised 9-bit word from a pixel byte.
module tm_choice
  import tmds_pkg::*;
(
  input  logic [7:0] data_in,
  output logic [8:0] qm_out
);
  logic [3:0] n1d;
  logic       use_xnor;
  logic [7:0] x;
  assign n1d      = popcount8(data_in);
  assign use_xnor = n1d > 4'd4 || (n1d == 4'd4 && !data_in[0]);
  for (genvar g = 0; g < 8; g++) begin : g_chain
    assign x[g] = ^data_in[g:0];
  end
  // each XNOR step adds one inversion, so odd positions of the XOR chain flip
  assign qm_out = {~use_xnor, x ^ (use_xnor ? 8'hAA : 8'h00)};
endmodule

// File: rtl/tmds_encoder.sv
// tmds_encoder: 8b/10b TMDS channel encoder with DC balancing and control symbols.
// Define TMDS_ENCODER_PIPE_EN to add a register between stage 1 and stage 2 (2-cycle latency).
module tmds_encoder
  import tmds_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic [1:0] control_in,
  input  logic       ve_in,
  output logic [9:0] tmds_out
);
  logic [8:0]  qm_raw, qm;
  logic        ve;
  logic [1:0]  ctrl;
  logic [3:0]  n1;
  tmds_tally_t tally, tally_nxt, diff;
  logic        case_a, case_b;
  logic [9:0]  ctrl_sym, sym;
  tm_choice u_tm (.data_in(data_in), .qm_out(qm_raw));
`ifdef TMDS_ENCODER_PIPE_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      qm   <= '0;
      ve   <= 1'b0;
      ctrl <= 2'b00;
    end else begin
      qm   <= qm_raw;
      ve   <= ve_in;
      ctrl <= control_in;
    end
  end
`else
  assign qm   = qm_raw;
  assign ve   = ve_in;
  assign ctrl = control_in;
`endif
  assign n1 = popcount8(qm[7:0]);
  // diff = n1 - n0 = 2*n1 - 8
  assign diff   = tmds_tally_t'({n1, 1'b0}) - 5'sd8;
  assign case_a = tally == 5'sd0 || diff == 5'sd0;
  assign case_b = (tally > 5'sd0 && diff > 5'sd0) || (tally < 5'sd0 && diff < 5'sd0);
  always_comb begin
    ctrl_sym  = ctrl == 2'b00 ? CTRL_00 : ctrl == 2'b01 ? CTRL_01 : ctrl == 2'b10 ? CTRL_10 : CTRL_11;
    sym       = !ve ? ctrl_sym :
                case_a ? {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]} :
                case_b ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm[8], qm[7:0]};
    tally_nxt = case_a ? (qm[8] ? tally + diff : tally - diff) :
                case_b ? tally + tmds_tally_t'({3'b0, qm[8], 1'b0}) - diff :
                tally + diff - tmds_tally_t'({3'b0, ~qm[8], 1'b0});
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tmds_out <= '0;
      tally    <= '0;
    end else begin
      tmds_out <= sym;
      tally    <= ve ? tally_nxt : '0;
    end
  end
endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: directed + random stimulus against an arithmetic TMDS reference model.
module tb_tmds_encoder;
  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] data_in = '0;
  logic [1:0] control_in = '0;
  logic       ve_in = 1'b0;
  logic [9:0] tmds_out;
  int errors = 0, checks = 0;
  logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic       lit_chk = 1'b0;
  logic [9:0] lit_val = '0;
  logic [9:0] exp_out = '0;
  logic       e_chk = 1'b0;
  logic [9:0] e_lit = '0;
  logic       armed = 1'b0;
  int         t = 0, tmin = 0, tmax = 0;
  int         tq [$];
  logic [7:0] p_d = '0;
  logic       p_v = 1'b0, p_chk = 1'b0;
  logic [1:0] p_c = '0;
  logic [9:0] p_lit = '0;

  tmds_encoder dut (.clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .control_in(control_in),
                    .ve_in(ve_in), .tmds_out(tmds_out));

  always #5 clk_in = ~clk_in;

  function automatic logic [9:0] enc(input logic [7:0] d, input logic v, input logic [1:0] c, inout int tl);
    int n1d, n1, n0;
    logic [8:0] q;
    logic xn;
    if (!v) begin
      tl = 0;
      return ctrl_tab[c];
    end
    n1d = $countones(d);
    xn = n1d > 4 || (n1d == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : q[i-1] ^ d[i];
    q[8] = !xn;
    n1 = $countones(q[7:0]);
    n0 = 8 - n1;
    if (tl == 0 || n1 == n0) begin
      tl += q[8] ? n1 - n0 : n0 - n1;
      return {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
    end
    if ((tl > 0 && n1 > n0) || (tl < 0 && n0 > n1)) begin
      tl += (q[8] ? 2 : 0) + n0 - n1;
      return {1'b1, q[8], ~q[7:0]};
    end
    tl += n1 - n0 - (q[8] ? 0 : 2);
    return {1'b0, q[8], q[7:0]};
  endfunction

  task automatic model_step();
    logic [7:0] sd;
    logic       sv, schk;
    logic [1:0] sc;
    logic [9:0] slit;
    armed = 1'b1;
    if (rst_in) begin
      exp_out = '0; t = 0; e_chk = lit_chk; e_lit = lit_val;
      p_d = '0; p_v = 1'b0; p_c = '0; p_chk = 1'b0; p_lit = '0;
    end else begin
`ifdef TMDS_ENCODER_PIPE_EN
      sd = p_d; sv = p_v; sc = p_c; schk = p_chk; slit = p_lit;
      p_d = data_in; p_v = ve_in; p_c = control_in; p_chk = lit_chk; p_lit = lit_val;
`else
      sd = data_in; sv = ve_in; sc = control_in; schk = lit_chk; slit = lit_val;
`endif
      exp_out = enc(sd, sv, sc, t);
      e_chk = schk; e_lit = slit;
      if (sv) tq.push_back(t);
      if (t < tmin) tmin = t;
      if (t > tmax) tmax = t;
    end
  endtask

  task automatic cycle(input logic [7:0] d, input logic v, input logic [1:0] c, input logic r,
                       input logic chk, input logic [9:0] lit);
    data_in = d; ve_in = v; control_in = c; rst_in = r; lit_chk = chk; lit_val = lit;
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic blank2();
    cycle(8'h00, 1'b0, 2'b00, 1'b0, 1'b0, '0);
    cycle(8'h00, 1'b0, 2'b00, 1'b0, 1'b0, '0);
  endtask

  task automatic chk_tally(input string name, input int idx, input int want);
    checks++;
    if (idx >= tq.size() || tq[idx] != want) begin
      errors++;
      $display("FAIL %s: model tally %0d required %0d", name, idx < tq.size() ? tq[idx] : 999, want);
    end
  endtask

  always @(negedge clk_in) begin
    if (armed) begin
      checks++;
      if (tmds_out !== exp_out) begin
        errors++;
        $display("FAIL model t=%0t: tmds_out=%h expected=%h", $time, tmds_out, exp_out);
      end
      if (e_chk) begin
        checks++;
        if (tmds_out !== e_lit) begin
          errors++;
          $display("FAIL literal t=%0t: tmds_out=%h required=%h", $time, tmds_out, e_lit);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) cycle(8'hA5, 1'b1, 2'b00, 1'b1, 1'b1, 10'h000);
    cycle(8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 10'b1101010100);
    cycle(8'h00, 1'b0, 2'b01, 1'b0, 1'b1, 10'b0010101011);
    cycle(8'h00, 1'b0, 2'b10, 1'b0, 1'b1, 10'b0101010100);
    cycle(8'h00, 1'b0, 2'b11, 1'b0, 1'b1, 10'b1010101011);
    tq.delete();
    cycle(8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 10'h100);
    cycle(8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 10'h3FF);
    cycle(8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 10'h100);
    blank2();
    chk_tally("neg_tally0", 0, -8);
    chk_tally("neg_tally1", 1, 2);
    chk_tally("neg_tally2", 2, -6);
    tq.delete();
    cycle(8'hFF, 1'b1, 2'b00, 1'b0, 1'b1, 10'h200);
    blank2();
    chk_tally("pos_tally", 0, -8);
    cycle(8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 10'h100);
    cycle(8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 10'b1101010100);
    cycle(8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 10'h100);
    cycle(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, '0);
    cycle(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, '0);
    cycle(8'h00, 1'b1, 2'b00, 1'b1, 1'b1, 10'h000);
    cycle(8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 10'h100);
    blank2();
    for (int i = 0; i < 10000; i++)
      cycle(8'($urandom), $urandom_range(15) != 0, 2'($urandom), 1'b0, 1'b0, '0);
    blank2();
    checks++;
    if (tmin < -8 || tmax > 8) begin
      errors++;
      $display("FAIL tally_range: min=%0d max=%0d required within -8..8", tmin, tmax);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
